// File: rtl/k_fft_pkg.sv
// k_fft_pkg: shared fixed-point types and rounding/range helpers for the FFT datapath.
package k_fft_pkg;
    localparam int CW = 16;

    typedef struct packed {
        logic signed [CW-1:0] re;
        logic signed [CW-1:0] im;
    } complex_t;

    typedef logic [1:0] scale_t;

    function automatic logic signed [63:0] round_shr(input logic signed [63:0] x, input int sh);
        if (sh <= 0) return x;
        return (x + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

    function automatic logic fits(input logic signed [63:0] x, input int w);
        return (x <= (64'sd1 <<< (w - 1)) - 64'sd1) && (x >= -(64'sd1 <<< (w - 1)));
    endfunction

    // Out-of-range values pass through unchanged when not saturating; the caller keeps the LSBs.
    function automatic logic signed [63:0] clip(input logic signed [63:0] x, input int w, input logic sat);
        if (!sat || fits(x, w)) return x;
        return (x < 64'sd0) ? -(64'sd1 <<< (w - 1)) : (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction
endpackage

// File: rtl/k_pipecmult.sv
// k_pipecmult: two-stage pipelined complex multiplier B*twiddle with rounding back to W+2 bits.
// A sideband word travels alongside each sample so callers can carry their own context.
module k_pipecmult
    import k_fft_pkg::*;
#(
    parameter int W  = 16,
    parameter int TW = 16,
    parameter int SW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [2*W-1:0]    i_b,
    input  logic [2*TW-1:0]   i_tw,
    input  logic [SW-1:0]     i_side,
    output logic              o_valid,
    output logic [2*W+3:0]    o_m,
    output logic [SW-1:0]     o_side
);
    logic signed [W-1:0]    w_br, w_bi;
    logic signed [TW-1:0]   w_wr, w_wi;
    logic signed [W+TW-1:0] r_rr, r_ii, r_ri, r_ir;
    logic signed [W+TW:0]   w_mre, w_mim;
    logic signed [W+1:0]    r_mre, r_mim;
    logic                   r_v1, r_v2;
    logic [SW-1:0]          r_s1, r_s2;

    assign w_br  = i_b[2*W-1:W];
    assign w_bi  = i_b[W-1:0];
    assign w_wr  = i_tw[2*TW-1:TW];
    assign w_wi  = i_tw[TW-1:0];
    assign w_mre = (W+TW+1)'(r_rr) - (W+TW+1)'(r_ii);
    assign w_mim = (W+TW+1)'(r_ri) + (W+TW+1)'(r_ir);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else if (i_en) begin
            r_v1  <= i_valid;
            r_v2  <= r_v1;
            r_s1  <= i_side;
            r_s2  <= r_s1;
            r_rr  <= (W+TW)'(w_br) * (W+TW)'(w_wr);
            r_ii  <= (W+TW)'(w_bi) * (W+TW)'(w_wi);
            r_ri  <= (W+TW)'(w_br) * (W+TW)'(w_wi);
            r_ir  <= (W+TW)'(w_bi) * (W+TW)'(w_wr);
            r_mre <= (W+2)'(round_shr(64'(w_mre), TW - 1));
            r_mim <= (W+2)'(round_shr(64'(w_mim), TW - 1));
        end
    end

    assign o_valid = r_v2;
    assign o_m     = {r_mre, r_mim};
    assign o_side  = r_s2;
endmodule

// File: rtl/k_pipebutterfly.sv
// k_pipebutterfly: 3-stage radix-2 DIT butterfly with per-sample scaling and overflow flags.
// Define K_BUTTERFLY_SAT_EN to saturate out-of-range results instead of wrapping.
module k_pipebutterfly
    import k_fft_pkg::*;
#(
    parameter int W  = 16,
    parameter int TW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*W-1:0]  in0,
    input  logic [2*W-1:0]  in1,
    input  logic [2*TW-1:0] twiddle,
    input  scale_t          scaling,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  out0,
    output logic [2*W-1:0]  out1,
    output logic            ovf,
    output logic            ovf_sticky,
    input  logic            clr
);
`ifdef K_BUTTERFLY_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic                   w_en, w_v2;
    logic [2*W+3:0]         w_m;
    logic [2*W+1:0]         w_side;
    logic signed [W-1:0]    w_are, w_aim;
    logic signed [W+1:0]    w_mre, w_mim;
    scale_t                 w_k;
    logic signed [63:0]     w_s [4];
    logic signed [63:0]     w_sc [4];
    logic [3:0]             w_ov;
    logic [3:0][W-1:0]      w_o;

    // Global stall: every stage holds while the output is blocked.
    assign in_ready = !(out_valid && !out_ready);
    assign w_en     = in_ready;

    k_pipecmult #(.W(W), .TW(TW), .SW(2*W+2)) u_cmult (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_en),
        .i_valid (in_valid),
        .i_b     (in1),
        .i_tw    (twiddle),
        .i_side  ({in0, scaling}),
        .o_valid (w_v2),
        .o_m     (w_m),
        .o_side  (w_side)
    );

    assign w_are = w_side[2*W+1:W+2];
    assign w_aim = w_side[W+1:2];
    assign w_k   = w_side[1:0];
    assign w_mre = w_m[2*W+3:W+2];
    assign w_mim = w_m[W+1:0];

    always_comb begin
        w_s[0] = 64'(w_are) + 64'(w_mre);
        w_s[1] = 64'(w_aim) + 64'(w_mim);
        w_s[2] = 64'(w_are) - 64'(w_mre);
        w_s[3] = 64'(w_aim) - 64'(w_mim);
        for (int j = 0; j < 4; j++) begin
            w_sc[j] = round_shr(w_s[j], int'(w_k));
            w_ov[j] = !fits(w_sc[j], W);
            w_o[j]  = W'(clip(w_sc[j], W, SAT));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out0      <= '0;
            out1      <= '0;
            ovf       <= 1'b0;
        end else if (w_en) begin
            out_valid <= w_v2;
            out0      <= {w_o[0], w_o[1]};
            out1      <= {w_o[2], w_o[3]};
            ovf       <= w_v2 && (|w_ov);
        end
    end

    // A coinciding overflow outranks clr.
    always_ff @(posedge clk) begin
        if (rst)
            ovf_sticky <= 1'b0;
        else if (out_valid && out_ready && ovf)
            ovf_sticky <= 1'b1;
        else if (clr)
            ovf_sticky <= 1'b0;
    end
endmodule

// File: tb/tb_k_pipebutterfly.sv
// tb_k_pipebutterfly: directed-vector bench for k_pipebutterfly at W = TW = 8.
module tb_k_pipebutterfly;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, ovf, ovf_sticky, clr;
    logic [15:0] in0, in1, twiddle, out0, out1;
    logic [1:0]  scaling;
    int          checks = 0, errors = 0;

    k_pipebutterfly #(.W(8), .TW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in0(in0), .in1(in1), .twiddle(twiddle), .scaling(scaling),
        .out_valid(out_valid), .out_ready(out_ready), .out0(out0), .out1(out1),
        .ovf(ovf), .ovf_sticky(ovf_sticky), .clr(clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Single sample through an idle pipe with out_ready high; returns at the negedge where it is visible.
    task automatic run1(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [15:0] tw,
                        input logic [1:0] sc, input logic [15:0] e0, input logic [15:0] e1, input logic eovf);
        @(negedge clk);
        in0 = a; in1 = b; twiddle = tw; scaling = sc; in_valid = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_early"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_out0"}, out0, e0);
        chk({tag, "_out1"}, out1, e1);
        chk({tag, "_ovf"}, ovf, eovf);
    endtask

    initial begin
        int sent, got, extra;
        logic [15:0] held;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in0 = '0; in1 = '0; twiddle = '0; scaling = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out0", out0, 0);
        chk("rst_out1", out1, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_sticky", ovf_sticky, 0);
        chk("rst_in_ready", in_ready, 1);

        run1("basic", 16'h2000, 16'h4000, 16'h7F00, 2'd0, 16'h6000, 16'hE000, 1'b0);
        run1("negj", 16'h2000, 16'h4000, 16'h0080, 2'd0, 16'h20C0, 16'h2040, 1'b0);
`ifdef K_BUTTERFLY_SAT_EN
        run1("ovf", 16'h7F00, 16'h7F00, 16'h7F00, 2'd0, 16'h7F00, 16'h0100, 1'b1);
`else
        run1("ovf", 16'h7F00, 16'h7F00, 16'h7F00, 2'd0, 16'hFD00, 16'h0100, 1'b1);
`endif
        @(negedge clk);
        chk("ovf_sticky_set", ovf_sticky, 1);
        run1("scale1", 16'h7F00, 16'h7F00, 16'h7F00, 2'd1, 16'h7F00, 16'h0100, 1'b0);

        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_sticky", ovf_sticky, 0);
`ifdef K_BUTTERFLY_SAT_EN
        run1("ovf2", 16'h7F00, 16'h7F00, 16'h7F00, 2'd0, 16'h7F00, 16'h0100, 1'b1);
`else
        run1("ovf2", 16'h7F00, 16'h7F00, 16'h7F00, 2'd0, 16'hFD00, 16'h0100, 1'b1);
`endif
        chk("pre_clr_sticky", ovf_sticky, 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_vs_ovf", ovf_sticky, 1);

        // Backpressure: B = 0 so each output equals its own A.
        sent = 0; got = 0; held = '0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc < 9);
            in_valid = (sent < 6);
            in0 = {8'(8'h10 + sent), 8'h00}; in1 = '0; twiddle = 16'h7F00; scaling = '0;
            #1;
            if (cyc == 5) begin
                chk("bp_stall_valid", out_valid, 1);
                chk("bp_stall_in_ready", in_ready, 0);
                held = out0;
            end
            if (cyc == 8) chk("bp_hold_out0", out0, held);
            if (out_valid && out_ready) begin
                chk("bp_order0", out0, {8'(8'h10 + got), 8'h00});
                chk("bp_order1", out1, {8'(8'h10 + got), 8'h00});
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_count", got, 6);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("bp_no_dup", extra, 0);

        // Reset mid-flight
        @(negedge clk);
        in0 = 16'h1100; in1 = 16'h2200; twiddle = 16'h7F00; in_valid = 1'b1;
        @(negedge clk);
        in0 = 16'h3300;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("rst_flight_none", extra, 0);
        chk("rst_flight_ready", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
